// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle pool and its scheduler.
package obstacle_pkg;

  typedef enum logic [1:0] {
    NONE         = 2'd0,
    CACTUS_SMALL = 2'd1,
    CACTUS_LARGE = 2'd2,
    PTERODACTYL  = 2'd3
  } type_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ARMED,
    FROZEN
  } sched_state_t;

  localparam int unsigned PTERO_MIN_SPEED = 8704;
  localparam int unsigned MULTI_SPEED     = 7168;

  // Rotation used when a type has repeated too often.
  function automatic type_t next_type(input type_t t, input logic ptero_ok);
    type_t r;
    case (t)
      CACTUS_SMALL: r = CACTUS_LARGE;
      CACTUS_LARGE: r = ptero_ok ? PTERODACTYL : CACTUS_SMALL;
      PTERODACTYL:  r = CACTUS_SMALL;
      default:      r = CACTUS_SMALL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Slot-side bundle between the scheduler and the obstacle instances.
interface obstacle_scheduler_if
  import obstacle_pkg::*;
#(
  parameter int unsigned SLOTS = 3
);

  logic [SLOTS-1:0]   remove;
  logic signed [10:0] x_pos [SLOTS];
  logic [9:0]         width [SLOTS];
  logic [10:0]        gap   [SLOTS];
  type_t              typ   [SLOTS];
  logic [1:0]         size  [SLOTS];
  logic [SLOTS-1:0]   start;

  modport master (
    input  remove, x_pos, width, gap,
    output typ, size, start
  );

  modport slave (
    output remove, x_pos, width, gap,
    input  typ, size, start
  );

endinterface

// File: rtl/obstacle_type_picker.sv
// Combinational choice of the next obstacle type, its size and the updated repeat count.
module obstacle_type_picker
  import obstacle_pkg::*;
#(
  parameter int unsigned DUP_W           = 2,
  parameter int unsigned MAX_DUP         = 2,
  parameter int unsigned PTERO_MIN_SPEED = obstacle_pkg::PTERO_MIN_SPEED,
  parameter int unsigned MULTI_SPEED     = obstacle_pkg::MULTI_SPEED
) (
  input  logic [3:0]       rng,
  input  logic [14:0]      speed,
  input  type_t            last_type,
  input  logic [DUP_W-1:0] dup_cnt,
  output type_t            pick_type,
  output logic [1:0]       pick_size,
  output logic [DUP_W-1:0] dup_next
);

  logic  ptero_ok;
  logic  multi_ok;
  logic  at_limit;
  type_t cand;

  assign ptero_ok = 32'(speed) >= PTERO_MIN_SPEED;
  assign multi_ok = 32'(speed) >= MULTI_SPEED;
  assign at_limit = 32'(dup_cnt) >= MAX_DUP;

  always_comb begin
    case (rng[1:0])
      2'd0, 2'd1: cand = CACTUS_SMALL;
      2'd2:       cand = CACTUS_LARGE;
      default:    cand = ptero_ok ? PTERODACTYL : CACTUS_LARGE;
    endcase

    pick_type = cand;
    if (cand == last_type && at_limit) begin
      pick_type = next_type(cand, ptero_ok);
    end

    if (pick_type != last_type) begin
      dup_next = DUP_W'(1);
    end else if (at_limit) begin
      dup_next = dup_cnt;
    end else begin
      dup_next = dup_cnt + 1'b1;
    end

    pick_size = 2'd1;
    if (pick_type != PTERODACTYL && multi_ok) begin
      case (rng[3:2])
        2'd1:    pick_size = 2'd2;
        2'd2:    pick_size = 2'd3;
        default: pick_size = 2'd1;
      endcase
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Spawns obstacles into a fixed slot pool on frame ticks and frees slots on removal.
module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter int unsigned SLOTS           = 3,
  parameter int unsigned SCREEN_WIDTH    = 600,
  parameter int unsigned CLEAR_FRAMES    = 180,
  parameter int unsigned MAX_DUP         = 2,
  parameter int unsigned PTERO_MIN_SPEED = obstacle_pkg::PTERO_MIN_SPEED,
  parameter int unsigned MULTI_SPEED     = obstacle_pkg::MULTI_SPEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic        run,
  input  logic        crash,
  input  logic [14:0] speed,
  input  logic [10:0] rng_data,
  obstacle_scheduler_if.master slots
);

  localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned CLR_W = ($clog2(CLEAR_FRAMES + 1) > 0) ? $clog2(CLEAR_FRAMES + 1) : 1;
  localparam int unsigned DUP_W = ($clog2(MAX_DUP + 1) > 0) ? $clog2(MAX_DUP + 1) : 1;

  sched_state_t       state;
  sched_state_t       state_next;
  logic [CLR_W-1:0]   clear_cnt;
  logic [DUP_W-1:0]   dup_cnt;
  logic [DUP_W-1:0]   dup_next;
  type_t              last_type;
  type_t              pick_type;
  logic [1:0]         pick_size;
  logic [IDX_W-1:0]   last_slot;
  logic [IDX_W-1:0]   target;
  logic               last_valid;
  type_t              typ_q  [SLOTS];
  logic [1:0]         size_q [SLOTS];
  logic [SLOTS-1:0]   start_q;
  logic [SLOTS-1:0]   free;
  logic               any_free;
  logic               last_free;
  logic               gap_ok;
  logic               clear_last;
  logic               evaluate;
  logic               spawn;
  logic               flush;
  logic signed [12:0] reach;
  logic               rng_unused;

  assign rng_unused = ^rng_data[10:4];

  always_comb begin
    free = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      free[i] = (typ_q[i] == NONE) || slots.remove[i];
    end
  end

  always_comb begin
    target   = '0;
    any_free = 1'b0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (free[i] && !any_free) begin
        target   = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

  assign last_free = !last_valid || free[last_slot];
  assign reach = {{2{slots.x_pos[last_slot][10]}}, slots.x_pos[last_slot]}
               + {3'b000, slots.width[last_slot]}
               + {2'b00, slots.gap[last_slot]};
  assign gap_ok = reach < $signed(13'(SCREEN_WIDTH));

  // The update that completes the clear delay is itself a spawn opportunity.
  assign clear_last = (32'(clear_cnt) + 32'd1) >= CLEAR_FRAMES;
  assign evaluate   = update && !crash &&
                      ((state == ARMED) || (state == WAIT && clear_last));
  assign spawn      = run && evaluate && any_free && (last_free || gap_ok);
  assign flush      = rst || !run || (state == IDLE);

  obstacle_type_picker #(
    .DUP_W          (DUP_W),
    .MAX_DUP        (MAX_DUP),
    .PTERO_MIN_SPEED(PTERO_MIN_SPEED),
    .MULTI_SPEED    (MULTI_SPEED)
  ) u_picker (
    .rng      (rng_data[3:0]),
    .speed    (speed),
    .last_type(last_type),
    .dup_cnt  (dup_cnt),
    .pick_type(pick_type),
    .pick_size(pick_size),
    .dup_next (dup_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run) state_next = WAIT;
      WAIT:    if (update && clear_last) state_next = ARMED;
      ARMED:   if (crash) state_next = FROZEN;
      FROZEN:  if (!crash) state_next = ARMED;
      default: state_next = IDLE;
    endcase
    if (!run) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      clear_cnt <= '0;
    end else if (state == WAIT && update && 32'(clear_cnt) != CLEAR_FRAMES) begin
      clear_cnt <= clear_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        typ_q[i]  <= NONE;
        size_q[i] <= 2'd1;
      end
      start_q    <= '0;
      last_slot  <= '0;
      last_valid <= 1'b0;
      last_type  <= NONE;
      dup_cnt    <= '0;
    end else begin
      start_q <= '0;
      if (state == WAIT || state == ARMED) begin
        for (int unsigned i = 0; i < SLOTS; i++) begin
          if (slots.remove[i]) typ_q[i] <= NONE;
        end
      end
      // Later assignment lets a spawn override a same-cycle removal of its slot.
      if (spawn) begin
        typ_q[target]   <= pick_type;
        size_q[target]  <= pick_size;
        start_q[target] <= 1'b1;
        last_slot       <= target;
        last_valid      <= 1'b1;
        last_type       <= pick_type;
        dup_cnt         <= dup_next;
      end
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_out
    assign slots.typ[g]  = typ_q[g];
    assign slots.size[g] = size_q[g];
  end
  assign slots.start = start_q;

endmodule
